nibble_serial_addsub: RTL

- Multi-cycle sequencer that performs WIDTH-bit add/subtract through one shared 4-bit carry-lookahead adder, one nibble per cycle, LSB nibble first.
- Carry between nibbles is held in a register.
- Sits between an ALU issue stage and the 4-bit CLA datapath.
- Uses valid/ready handshakes on both the request and result sides.

---
 rtl/nibble_serial_addsub_pkg.sv | 16 +
 rtl/nibble_serial_addsub_cla.sv | 28 ++
 rtl/nibble_serial_addsub.sv | 129 ++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_addsub_pkg;

  localparam int NIB_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_ILLEGAL = 2'd3
  } state_t;

endpackage

// File: rtl/nibble_serial_addsub_cla.sv
// 4-bit carry-lookahead adder shared by every nibble step of the sequencer.
module carry_look_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries expanded in two-level form so no carry ripples through p/g.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract sequenced one nibble per cycle through a single 4-bit CLA,
// with valid/ready handshakes on the request and result sides.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CNT_W   = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]       cnt;
  logic                   carry;
  logic [WIDTH-1:0]       a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [WIDTH-NIB_W-1:0] sum_sh;
  logic                   a_msb;
  logic                   b_msb;
  logic [WIDTH-1:0]       b_eff;
  logic [NIB_W-1:0]       cla_sum;
  logic                   cla_cout;
  logic [WIDTH-1:0]       sum_next;
  logic                   last_nib;

  assign b_eff    = (op_sub == OP_SUB) ? ~b : b;
  assign last_nib = (cnt == LAST_CNT);
  assign sum_next = {cla_sum, sum_sh};

  carry_look_adder u_cla (
    .a    (a_sh[NIB_W-1:0]),
    .b    (b_sh[NIB_W-1:0]),
    .cin  (carry),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_valid) state_next = S_RUN;
        else             state_next = S_IDLE;
      end
      S_RUN: begin
        if (last_nib) state_next = S_DONE;
        else          state_next = S_RUN;
      end
      S_DONE: begin
        if (res_ready) state_next = S_IDLE;
        else           state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Partial sums accumulate in sum_sh so result only changes when an operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= (op_sub == OP_SUB);
            a_msb <= a[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
            cnt   <= '0;
          end
        end
        S_RUN: begin
          sum_sh <= sum_next[WIDTH-1:NIB_W];
          a_sh   <= a_sh >> NIB_W;
          b_sh   <= b_sh >> NIB_W;
          carry  <= cla_cout;
          cnt    <= cnt + CNT_W'(1);
          if (last_nib) begin
            result   <= sum_next;
            cout     <= cla_cout;
            overflow <= (a_msb ~^ b_msb) & (cla_sum[NIB_W-1] ^ a_msb);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign start_ready = (state == S_IDLE);
  assign res_valid   = (state == S_DONE);
  assign busy        = (state != S_IDLE);

endmodule
